// File: rtl/lock_disp_pkg.sv
// Glyph constants, message codes and the message-to-glyph lookup
// shared by the lock display scanner.
package lock_disp_pkg;

    localparam logic [6:0] SEG_L     = 7'h38;
    localparam logic [6:0] SEG_O     = 7'h3F;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_K     = 7'h76;
    localparam logic [6:0] SEG_P     = 7'h73;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_N     = 7'h54;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        MSG_LOCK = 2'd0,
        MSG_OPEN = 2'd1,
        MSG_ERR  = 2'd2,
        MSG_DASH = 2'd3
    } msg_e;

    // pos 3 is the leftmost character; anything past 3 is blank
    function automatic logic [6:0] msg_char(input msg_e msg, input logic [31:0] pos);
        logic [6:0] g;
        g = SEG_BLANK;
        if (pos < 32'd4) begin
            unique case (msg)
                MSG_LOCK: begin
                    case (pos[1:0])
                        2'd3:    g = SEG_L;
                        2'd2:    g = SEG_O;
                        2'd1:    g = SEG_C;
                        default: g = SEG_K;
                    endcase
                end
                MSG_OPEN: begin
                    case (pos[1:0])
                        2'd3:    g = SEG_O;
                        2'd2:    g = SEG_P;
                        2'd1:    g = SEG_E;
                        default: g = SEG_N;
                    endcase
                end
                MSG_ERR: begin
                    case (pos[1:0])
                        2'd3:    g = SEG_E;
                        2'd2:    g = SEG_R;
                        2'd1:    g = SEG_R;
                        default: g = SEG_BLANK;
                    endcase
                end
                MSG_DASH: g = SEG_DASH;
            endcase
        end
        return g;
    endfunction

endpackage

// File: rtl/lock_char_rom.sv
// Combinational character ROM: active message and digit position
// to the 7-segment glyph (bit0=a .. bit6=g).
module lock_char_rom
    import lock_disp_pkg::*;
#(
    parameter int IW = 2
) (
    input  msg_e          msg_i,
    input  logic [IW-1:0] pos_i,
    output logic [6:0]    seg_o
);

    assign seg_o = msg_char(msg_i, 32'(pos_i));

endmodule

// File: rtl/lock_msg_scanner.sv
// Multi-digit lock-status display scanner with frame-aligned message
// switching and whole-display blink.
module lock_msg_scanner
    import lock_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 250,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            msg_sel,
    input  logic                  load,
    input  logic                  blink_en,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  scan_tick,
    output logic                  frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  phase_q, phase_d;
    msg_e                  act_q, act_d;
    msg_e                  pend_q, pend_d;
    logic                  pv_q, pv_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic [6:0]            rom_seg;

    lock_char_rom #(
        .IW (IW)
    ) u_rom (
        .msg_i (act_q),
        .pos_i (idx_q),
        .seg_o (rom_seg)
    );

    assign scan_tick   = (cnt_q == CNT_MAX);
    assign frame_start = scan_tick && (idx_q == IDX_MAX);

    always_comb begin
        cnt_d   = scan_tick ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (scan_tick) begin
            idx_d = frame_start ? '0 : idx_q + IW'(1);
            if (bcnt_q == BCNT_MAX) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end

        act_d  = act_q;
        pend_d = pend_q;
        pv_d   = pv_q;
        if (frame_start && pv_q) begin
            act_d = pend_q;
            pv_d  = 1'b0;
        end
        // a load on the wrap cycle lands in pending for the next frame
        if (load) begin
            pend_d = msg_e'(msg_sel);
            pv_d   = 1'b1;
        end

        seg_d = (blink_en && phase_q) ? SEG_BLANK : rom_seg;
        dig_d = NUM_DIGITS'(1) << idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            act_q   <= MSG_LOCK;
            pend_q  <= MSG_LOCK;
            pv_q    <= 1'b0;
            seg_q   <= '0;
            dig_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pv_q    <= pv_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign seg    = ACTIVE_LOW ? ~seg_q : seg_q;
    assign dig_en = ACTIVE_LOW ? ~dig_q : dig_q;

endmodule

// File: tb/tb_lock_msg_scanner.sv
// Bench for lock_msg_scanner: a 4-digit active-high and a 6-digit
// active-low instance on shared stimulus, checked against a time-based model.
module tb_lock_msg_scanner;

    logic       clk;
    logic       rst_n;
    logic [1:0] msg_sel;
    logic       load;
    logic       blink_en;

    logic [6:0] seg0, seg1;
    logic [3:0] dig0;
    logic [5:0] dig1;
    logic       tk0, fs0, tk1, fs1;

    int nvec;
    int nerr;

    lock_msg_scanner #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .BLINK_DIV  (2),
        .ACTIVE_LOW (1'b0)
    ) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .msg_sel     (msg_sel),
        .load        (load),
        .blink_en    (blink_en),
        .seg         (seg0),
        .dig_en      (dig0),
        .scan_tick   (tk0),
        .frame_start (fs0)
    );

    lock_msg_scanner #(
        .NUM_DIGITS (6),
        .SCAN_DIV   (3),
        .BLINK_DIV  (1),
        .ACTIVE_LOW (1'b1)
    ) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .msg_sel     (msg_sel),
        .load        (load),
        .blink_en    (blink_en),
        .seg         (seg1),
        .dig_en      (dig1),
        .scan_tick   (tk1),
        .frame_start (fs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Glyphs per message, indexed by digit position 0..3 (3 = leftmost)
    logic [6:0] gl [4][4];

    // Model state: edges since reset release, message state per instance,
    // and the glyph/digit the output registers should hold.
    int          m;
    logic [1:0]  act  [2];
    logic [1:0]  pend [2];
    logic        pv   [2];
    logic [6:0]  es   [2];
    logic [31:0] ed   [2];

    function automatic int p_sd(int d); return d ? 3 : 4; endfunction
    function automatic int p_n (int d); return d ? 6 : 4; endfunction
    function automatic int p_bd(int d); return d ? 1 : 2; endfunction

    task automatic model_reset();
        m = 0;
        for (int d = 0; d < 2; d++) begin
            act[d]  = 2'd0;
            pend[d] = 2'd0;
            pv[d]   = 1'b0;
            es[d]   = 7'h00;
            ed[d]   = 32'h0;
        end
    endtask

    task automatic model_edge();
        int sd, n, bd, tk, ix;
        logic ph;
        logic [6:0] g;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            sd = p_sd(d);
            n  = p_n(d);
            bd = p_bd(d);
            tk = m / sd;
            ix = tk % n;
            ph = ((tk / bd) % 2) == 1;
            g  = (ix < 4) ? gl[act[d]][ix] : 7'h00;
            if (blink_en && ph) g = 7'h00;
            es[d] = g;
            ed[d] = 32'(1) << ix;
            if ((m % sd == sd - 1) && (ix == n - 1) && pv[d]) begin
                act[d] = pend[d];
                pv[d]  = 1'b0;
            end
            if (load) begin
                pend[d] = msg_sel;
                pv[d]   = 1'b1;
            end
        end
        m++;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h want %h (t=%0t m=%0d)", nm, got, want, $time, m);
        end
    endtask

    task automatic chk_dut(input int d, input logic [6:0] s, input logic [31:0] dg,
                           input logic t, input logic f);
        int sd, n;
        logic [6:0] ws;
        logic [31:0] wd, mask;
        logic wt, wf;
        sd   = p_sd(d);
        n    = p_n(d);
        mask = (32'(1) << n) - 32'(1);
        ws   = d ? ~es[d] : es[d];
        wd   = d ? (~ed[d] & mask) : ed[d];
        wt   = (m % sd) == sd - 1;
        wf   = wt && ((m / sd) % n == n - 1);
        chk(d ? "seg1" : "seg0", 32'(s), 32'(ws));
        chk(d ? "dig1" : "dig0", dg, wd);
        chk(d ? "tick1" : "tick0", 32'(t), 32'(wt));
        chk(d ? "frame1" : "frame0", 32'(f), 32'(wf));
    endtask

    task automatic check_all();
        chk_dut(0, seg0, 32'(dig0), tk0, fs0);
        chk_dut(1, seg1, 32'(dig1), tk1, fs1);
    endtask

    // Drive inputs at the falling edge, advance one clock, check at the next fall
    task automatic step(input logic ld, input logic [1:0] ms, input logic be);
        load     = ld;
        msg_sel  = ms;
        blink_en = be;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        logic       ld;
        logic [1:0] ms;
        logic       be;
        logic [3:0] dig;
        logic [6:0] seg;
        logic       tk;
        logic       fs;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic be;
        nvec = 0;
        nerr = 0;

        gl[0] = '{7'h76, 7'h39, 7'h3F, 7'h38};
        gl[1] = '{7'h54, 7'h79, 7'h73, 7'h3F};
        gl[2] = '{7'h00, 7'h50, 7'h50, 7'h79};
        gl[3] = '{7'h40, 7'h40, 7'h40, 7'h40};

        // Expected dut0 outputs after edge i+1; row 5 loads OPEn at index 1
        tbl[0]  = '{1'b0, 2'd2, 1'b0, 4'h1, 7'h76, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 4'h1, 7'h76, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 2'd2, 1'b0, 4'h1, 7'h76, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 2'd2, 1'b0, 4'h1, 7'h76, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 2'd2, 1'b0, 4'h2, 7'h39, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 4'h2, 7'h39, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 2'd3, 1'b0, 4'h2, 7'h39, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 2'd3, 1'b0, 4'h2, 7'h39, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 2'd3, 1'b0, 4'h4, 7'h3F, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 2'd3, 1'b0, 4'h4, 7'h3F, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 2'd3, 1'b0, 4'h4, 7'h3F, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 2'd3, 1'b0, 4'h4, 7'h3F, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'd3, 1'b0, 4'h8, 7'h38, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 2'd3, 1'b0, 4'h8, 7'h38, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 2'd3, 1'b0, 4'h8, 7'h38, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 2'd3, 1'b0, 4'h8, 7'h38, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 2'd3, 1'b0, 4'h1, 7'h54, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 2'd3, 1'b0, 4'h1, 7'h54, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 2'd3, 1'b0, 4'h1, 7'h54, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 2'd3, 1'b0, 4'h1, 7'h54, 1'b0, 1'b0};

        rst_n    = 1'b0;
        load     = 1'b0;
        msg_sel  = 2'd0;
        blink_en = 1'b0;
        model_reset();

        #3;
        chk("rst_seg0", 32'(seg0), 32'h00);
        chk("rst_dig0", 32'(dig0), 32'h0);
        chk("rst_seg1", 32'(seg1), 32'h7F);
        chk("rst_dig1", 32'(dig1), 32'h3F);
        @(negedge clk);
        step(1'b1, 2'd3, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].ld, tbl[i].ms, tbl[i].be);
            chk($sformatf("tbl%0d_dig", i), 32'(dig0), 32'(tbl[i].dig));
            chk($sformatf("tbl%0d_seg", i), 32'(seg0), 32'(tbl[i].seg));
            chk($sformatf("tbl%0d_tick", i), 32'(tk0), 32'(tbl[i].tk));
            chk($sformatf("tbl%0d_frame", i), 32'(fs0), 32'(tbl[i].fs));
        end

        // Two loads in one frame: only the last (dashes) is shown
        step(1'b1, 2'd2, 1'b0);
        repeat (3) step(1'b0, 2'd0, 1'b0);
        step(1'b1, 2'd3, 1'b0);
        repeat (12) step(1'b0, 2'd1, 1'b0);
        chk("last_load_wins", 32'(seg0), 32'h40);

        // Load on the wrap cycle waits one full frame
        repeat (10) step(1'b0, 2'd0, 1'b0);
        chk("wrap_frame", 32'(fs0), 32'h1);
        step(1'b1, 2'd0, 1'b0);
        repeat (15) step(1'b0, 2'd2, 1'b0);
        chk("coincident_old", 32'(seg0), 32'h40);
        repeat (2) step(1'b0, 2'd2, 1'b0);
        chk("coincident_new_seg", 32'(seg0), 32'h76);
        chk("coincident_new_dig", 32'(dig0), 32'h1);

        // Blink on, then off
        repeat (40) step(1'b0, 2'd1, 1'b1);
        repeat (6) step(1'b0, 2'd1, 1'b0);
        repeat (20) step(1'b0, 2'd1, 1'b1);
        step(1'b0, 2'd1, 1'b0);

        // Reset at index 2 with a message pending
        for (int i = 0; i < 16; i++) begin
            if (m % 16 == 8) break;
            step(1'b0, 2'd0, 1'b0);
        end
        step(1'b1, 2'd1, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_seg0", 32'(seg0), 32'h00);
        chk("async_dig0", 32'(dig0), 32'h0);
        chk("async_seg1", 32'(seg1), 32'h7F);
        chk("async_dig1", 32'(dig1), 32'h3F);
        @(negedge clk);
        step(1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 2'd0, 1'b0);
        chk("post_rst_dig0", 32'(dig0), 32'h1);
        chk("post_rst_seg0", 32'(seg0), 32'h76);
        repeat (40) step(1'b0, 2'd1, 1'b0);

        be = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (i % 37 == 0) be = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), be);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
